// File: rtl/adc_avg_gain_if.sv
// Sample, calibration and result bundle of the ADC averaging block.
// The converter drives the results through the slave modport.
interface adc_avg_gain_if #(
    parameter int unsigned ADC_WIDTH   = 12,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FLOAT_WIDTH = 64
);
    logic [NUM_CH*ADC_WIDTH-1:0]   ADC_DATA_IN;
    logic                          enable;
    logic                          CONTINUOUS;
    logic [FLOAT_WIDTH-1:0]        GAIN_IN;
    logic [FLOAT_WIDTH-1:0]        OFFSET_IN;
    logic [NUM_CH*FLOAT_WIDTH-1:0] DATA_OUT;
    logic                          REG_WRITE;
    logic                          REG_RST;
    logic                          BUSY;
    logic                          DONE;

    modport master (
        output ADC_DATA_IN, enable, CONTINUOUS, GAIN_IN, OFFSET_IN,
        input  DATA_OUT, REG_WRITE, REG_RST, BUSY, DONE
    );

    modport slave (
        input  ADC_DATA_IN, enable, CONTINUOUS, GAIN_IN, OFFSET_IN,
        output DATA_OUT, REG_WRITE, REG_RST, BUSY, DONE
    );
endinterface

// File: rtl/adc_avg_gain.sv
// Per-channel boxcar average over 2^LOG2_SAMPS samples followed by a saturating
// 16Q48 gain multiply and offset add; results are published together.
module adc_avg_gain #(
    parameter int unsigned ADC_WIDTH   = 12,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned LOG2_SAMPS  = 10,
    parameter int unsigned FLOAT_WIDTH = 64
) (
    input logic           ADC_CLK,
    input logic           RST,
    adc_avg_gain_if.slave bus
);

    localparam int unsigned ACC_W  = ADC_WIDTH + LOG2_SAMPS;
    localparam int unsigned PROD_W = FLOAT_WIDTH + ADC_WIDTH + 1;

    localparam logic [FLOAT_WIDTH-1:0] SAT_MAX = {1'b0, {(FLOAT_WIDTH-1){1'b1}}};
    localparam logic [FLOAT_WIDTH-1:0] SAT_MIN = {1'b1, {(FLOAT_WIDTH-1){1'b0}}};
    localparam logic [LOG2_SAMPS-1:0]  CNT_LAST = '1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] ACCUM = 3'd2;
    localparam logic [2:0] MUL   = 3'd3;
    localparam logic [2:0] ADD   = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;
    localparam logic [2:0] HOLD  = 3'd6;

    logic [2:0]                    state_q, state_d;
    logic [LOG2_SAMPS-1:0]         cnt_q;
    logic [ACC_W-1:0]              acc_q     [NUM_CH];
    logic [FLOAT_WIDTH-1:0]        prod_q    [NUM_CH];
    logic [FLOAT_WIDTH-1:0]        sum_q     [NUM_CH];
    logic [FLOAT_WIDTH-1:0]        prod_next [NUM_CH];
    logic [FLOAT_WIDTH-1:0]        sum_next  [NUM_CH];
    logic [FLOAT_WIDTH-1:0]        gain_q, offset_q;
    logic [NUM_CH*FLOAT_WIDTH-1:0] data_out_q;
    logic                          reg_write_q, reg_rst_q, done_q;

    // The product of an unsigned average and a signed gain always fits PROD_W bits,
    // so saturation only has to inspect the bits above the result sign.
    function automatic logic [FLOAT_WIDTH-1:0] scale(input logic [ACC_W-1:0]       acc,
                                                      input logic [FLOAT_WIDTH-1:0] gain);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] g;
        logic signed [PROD_W-1:0] p;
        a = $signed(PROD_W'(acc >> LOG2_SAMPS));
        g = $signed({{(PROD_W-FLOAT_WIDTH){gain[FLOAT_WIDTH-1]}}, gain});
        p = a * g;
        if (&p[PROD_W-1:FLOAT_WIDTH-1] || ~|p[PROD_W-1:FLOAT_WIDTH-1]) begin
            return p[FLOAT_WIDTH-1:0];
        end
        return p[PROD_W-1] ? SAT_MIN : SAT_MAX;
    endfunction

    function automatic logic [FLOAT_WIDTH-1:0] add_sat(input logic [FLOAT_WIDTH-1:0] x,
                                                        input logic [FLOAT_WIDTH-1:0] y);
        logic [FLOAT_WIDTH:0] s;
        s = {x[FLOAT_WIDTH-1], x} + {y[FLOAT_WIDTH-1], y};
        if (s[FLOAT_WIDTH] == s[FLOAT_WIDTH-1]) begin
            return s[FLOAT_WIDTH-1:0];
        end
        return s[FLOAT_WIDTH] ? SAT_MIN : SAT_MAX;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            prod_next[k] = scale(acc_q[k], gain_q);
            sum_next[k]  = add_sat(prod_q[k], offset_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = CLEAR;
            CLEAR:   state_d = bus.enable ? ACCUM : IDLE;
            ACCUM: begin
                if (!bus.enable)           state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = MUL;
            end
            MUL:     state_d = bus.enable ? ADD : IDLE;
            ADD:     state_d = bus.enable ? WRITE : IDLE;
            WRITE:   state_d = (bus.CONTINUOUS && bus.enable) ? CLEAR : HOLD;
            HOLD:    if (!bus.enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gain_q      <= '0;
            offset_q    <= '0;
            data_out_q  <= '0;
            reg_write_q <= 1'b0;
            reg_rst_q   <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]  <= '0;
                prod_q[k] <= '0;
                sum_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            reg_write_q <= 1'b0;
            reg_rst_q   <= 1'b0;
            case (state_q)
                // An abort while in CLEAR must leave DONE and the latched values alone.
                CLEAR: if (bus.enable) begin
                    cnt_q     <= '0;
                    gain_q    <= bus.GAIN_IN;
                    offset_q  <= bus.OFFSET_IN;
                    reg_rst_q <= 1'b1;
                    done_q    <= 1'b0;
                    for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
                end
                ACCUM: if (bus.enable) begin
                    cnt_q <= cnt_q + LOG2_SAMPS'(1);
                    for (int k = 0; k < NUM_CH; k++) begin
                        acc_q[k] <= acc_q[k] + ACC_W'(bus.ADC_DATA_IN[k*ADC_WIDTH +: ADC_WIDTH]);
                    end
                end
                MUL: for (int k = 0; k < NUM_CH; k++) prod_q[k] <= prod_next[k];
                ADD: for (int k = 0; k < NUM_CH; k++) sum_q[k] <= sum_next[k];
                WRITE: begin
                    reg_write_q <= 1'b1;
                    done_q      <= 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        data_out_q[k*FLOAT_WIDTH +: FLOAT_WIDTH] <= sum_q[k];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.DATA_OUT  = data_out_q;
    assign bus.REG_WRITE = reg_write_q;
    assign bus.REG_RST   = reg_rst_q;
    assign bus.DONE      = done_q;
    assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_adc_avg_gain.sv
// Scoreboard bench for adc_avg_gain with four-sample averaging on two channels.
module tb_adc_avg_gain;

    localparam int unsigned ADC_WIDTH   = 12;
    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned LOG2_SAMPS  = 2;
    localparam int unsigned FLOAT_WIDTH = 64;
    localparam logic [63:0] ONE = 64'h0001_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_avg_gain_if #(
        .ADC_WIDTH  (ADC_WIDTH),
        .NUM_CH     (NUM_CH),
        .FLOAT_WIDTH(FLOAT_WIDTH)
    ) bus ();

    adc_avg_gain #(
        .ADC_WIDTH  (ADC_WIDTH),
        .NUM_CH     (NUM_CH),
        .LOG2_SAMPS (LOG2_SAMPS),
        .FLOAT_WIDTH(FLOAT_WIDTH)
    ) dut (
        .ADC_CLK(clk),
        .RST    (rst),
        .bus    (bus)
    );

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_out = '0;

    always @(negedge clk) begin
        if (bus.REG_WRITE === 1'b1) begin
            checks++;
            if (bus.REG_RST !== 1'b0) begin
                errors++;
                $display("FAIL strobe_overlap: REG_RST=%b required 0 while REG_WRITE=1", bus.REG_RST);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] model(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] c, input logic [11:0] d,
                                          input logic [63:0] g, input logic [63:0] o);
        logic signed [127:0] avg, gs, os, p, hi, lo;
        hi  = {64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
        lo  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        avg = (128'(a) + 128'(b) + 128'(c) + 128'(d)) / 4;
        gs  = {{64{g[63]}}, g};
        os  = {{64{o[63]}}, o};
        p   = avg * gs;
        if (p > hi) p = hi;
        else if (p < lo) p = lo;
        p = p + os;
        if (p > hi) p = hi;
        else if (p < lo) p = lo;
        return p[63:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion; lat is the edge index of REG_WRITE (edge 0 samples enable).
    task automatic drive_conv(input logic [11:0] a0, input logic [11:0] a1,
                              input logic [11:0] a2, input logic [11:0] a3,
                              input logic [11:0] c1, input logic [63:0] g,
                              input logic [63:0] o, output int lat);
        exp_q.push_back({model(c1, c1, c1, c1, g, o), model(a0, a1, a2, a3, g, o)});
        bus.GAIN_IN     = g;
        bus.OFFSET_IN   = o;
        bus.ADC_DATA_IN = {c1, a0};
        bus.enable      = 1'b1;
        lat = -1;
        for (int e = 0; e < 20 && lat < 0; e++) begin
            tick();
            case (e)
                2: bus.ADC_DATA_IN = {c1, a1};
                3: bus.ADC_DATA_IN = {c1, a2};
                4: bus.ADC_DATA_IN = {c1, a3};
                default: ;
            endcase
            @(negedge clk);
            if (bus.REG_WRITE === 1'b1) lat = e;
        end
    endtask

    task automatic end_conv();
        bus.enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        int strobes;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.CONTINUOUS = 1'b0;
        bus.GAIN_IN = '0;
        bus.OFFSET_IN = '0;
        bus.ADC_DATA_IN = '0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({bus.DATA_OUT, bus.REG_WRITE, bus.REG_RST, bus.BUSY, bus.DONE} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h wr=%b rst=%b busy=%b done=%b, required all 0",
                     bus.DATA_OUT, bus.REG_WRITE, bus.REG_RST, bus.BUSY, bus.DONE);
        end
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.REG_WRITE || bus.REG_RST || bus.BUSY) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d active cycles, required 0", strobes);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [127:0] exp;
        drive_conv(12'd100, 12'd100, 12'd100, 12'd100, 12'd0, ONE, 64'd0, lat);
        exp = exp_q.pop_front();
        last_out = exp;
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: REG_WRITE at edge %0d, required 8", lat);
        end
        checks++;
        if (bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL basic_data: got %h required %h", bus.DATA_OUT, exp);
        end
        checks++;
        if (bus.DATA_OUT !== {64'd0, 64'h0064_0000_0000_0000}) begin
            errors++;
            $display("FAIL basic_literal: got %h required ch0=0064_0000_0000_0000 ch1=0", bus.DATA_OUT);
        end
        checks++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: DONE=%b BUSY=%b, required 1 1", bus.DONE, bus.BUSY);
        end
        @(negedge clk);
        checks++;
        if (bus.REG_WRITE !== 1'b0) begin
            errors++;
            $display("FAIL basic_strobe_width: REG_WRITE=%b one cycle later, required 0", bus.REG_WRITE);
        end
        end_conv();
    endtask

    task automatic test_trunc();
        int lat;
        logic [127:0] exp;
        drive_conv(12'd1, 12'd2, 12'd3, 12'd5, 12'd7, ONE, 64'd0, lat);
        exp = exp_q.pop_front();
        last_out = exp;
        checks++;
        if (lat != 8 || bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL trunc_data: lat=%0d got %h, required lat 8 data %h", lat, bus.DATA_OUT, exp);
        end
        checks++;
        if (bus.DATA_OUT[63:0] !== 64'h0002_0000_0000_0000) begin
            errors++;
            $display("FAIL trunc_literal: ch0 got %h required 0002_0000_0000_0000", bus.DATA_OUT[63:0]);
        end
        end_conv();
    endtask

    task automatic test_saturation();
        int lat;
        logic [127:0] exp;
        drive_conv(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'd1, 64'h0014_0000_0000_0000, 64'd0, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 8 || bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL sat_pos_data: lat=%0d got %h, required lat 8 data %h", lat, bus.DATA_OUT, exp);
        end
        checks++;
        if (bus.DATA_OUT[63:0] !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL sat_pos_literal: ch0 got %h required 7FFF_FFFF_FFFF_FFFF", bus.DATA_OUT[63:0]);
        end
        end_conv();
        drive_conv(12'd2, 12'd2, 12'd2, 12'd2, 12'd0, 64'h8000_0000_0000_0000, 64'd0, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 8 || bus.DATA_OUT !== {64'd0, 64'h8000_0000_0000_0000} || bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL sat_neg_data: lat=%0d got %h, required lat 8 data %h", lat, bus.DATA_OUT, exp);
        end
        end_conv();
    endtask

    task automatic test_offset();
        int lat;
        logic [127:0] exp;
        drive_conv(12'd10, 12'd10, 12'd10, 12'd10, 12'd0, ONE, 64'hFFEC_0000_0000_0000, lat);
        exp = exp_q.pop_front();
        last_out = exp;
        checks++;
        if (lat != 8 || bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL offset_data: lat=%0d got %h, required lat 8 data %h", lat, bus.DATA_OUT, exp);
        end
        checks++;
        if (bus.DATA_OUT !== {64'hFFEC_0000_0000_0000, 64'hFFF6_0000_0000_0000}) begin
            errors++;
            $display("FAIL offset_literal: got %h required FFEC_0000_0000_0000 FFF6_0000_0000_0000",
                     bus.DATA_OUT);
        end
        end_conv();
    endtask

    task automatic test_abort();
        int writes;
        bus.ADC_DATA_IN = {12'd300, 12'd300};
        bus.enable = 1'b1;
        repeat (3) tick();
        bus.enable = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: BUSY=%b after abort, required 0", bus.BUSY);
        end
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.REG_WRITE) writes++;
        end
        checks++;
        if (writes != 0 || bus.DATA_OUT !== last_out) begin
            errors++;
            $display("FAIL abort_hold: writes=%0d data=%h, required 0 writes data %h",
                     writes, bus.DATA_OUT, last_out);
        end
    endtask

    task automatic test_rst_mid();
        bus.ADC_DATA_IN = {12'd5, 12'd5};
        bus.enable = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({bus.DATA_OUT, bus.REG_WRITE, bus.REG_RST, bus.BUSY, bus.DONE} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got data=%h wr=%b rst=%b busy=%b done=%b, required all 0",
                     bus.DATA_OUT, bus.REG_WRITE, bus.REG_RST, bus.BUSY, bus.DONE);
        end
        rst = 1'b0;
        bus.enable = 1'b0;
        last_out = '0;
        tick();
    endtask

    task automatic test_continuous();
        logic [63:0]  g1, g2;
        logic [127:0] exp;
        int           n;
        bit           rst_seen;
        g1 = 64'h0002_0000_0000_0000;
        g2 = 64'h0003_0000_0000_0000;
        exp_q.push_back({model(7, 7, 7, 7, g1, 0), model(50, 50, 50, 50, g1, 0)});
        exp_q.push_back({model(7, 7, 7, 7, g2, 0), model(50, 50, 50, 50, g2, 0)});
        exp_q.push_back({model(7, 7, 7, 7, g2, 0), model(50, 50, 50, 50, g2, 0)});
        bus.ADC_DATA_IN = {12'd7, 12'd50};
        bus.GAIN_IN = g1;
        bus.OFFSET_IN = '0;
        bus.CONTINUOUS = 1'b1;
        bus.enable = 1'b1;
        n = 0;
        rst_seen = 1'b0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (e == 4) bus.GAIN_IN = g2;
            @(negedge clk);
            if (bus.REG_RST === 1'b1) rst_seen = 1'b1;
            if (bus.REG_WRITE === 1'b1) begin
                exp = exp_q.size() > 0 ? exp_q.pop_front() : '0;
                checks++;
                if (e != 8 * (n + 1) || !rst_seen || bus.DATA_OUT !== exp) begin
                    errors++;
                    $display("FAIL cont_write%0d: edge=%0d rst_seen=%0b data=%h, required edge %0d rst_seen 1 data %h",
                             n, e, rst_seen, bus.DATA_OUT, 8 * (n + 1), exp);
                end
                n++;
                rst_seen = 1'b0;
                if (n == 3) bus.enable = 1'b0;
            end
        end
        checks++;
        if (n != 3 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cont_count: writes=%0d BUSY=%b, required 3 writes BUSY 0", n, bus.BUSY);
        end
        bus.CONTINUOUS = 1'b0;
        last_out = {model(7, 7, 7, 7, g2, 0), model(50, 50, 50, 50, g2, 0)};
    endtask

    task automatic test_single_hold();
        int lat, writes, idle_cycles;
        logic [127:0] exp;
        drive_conv(12'd9, 12'd9, 12'd9, 12'd9, 12'd4, ONE, ONE, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 8 || bus.DATA_OUT !== exp) begin
            errors++;
            $display("FAIL single_data: lat=%0d got %h, required lat 8 data %h", lat, bus.DATA_OUT, exp);
        end
        writes = 0;
        idle_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.REG_WRITE) writes++;
            if (!bus.BUSY) idle_cycles++;
        end
        checks++;
        if (writes != 0 || idle_cycles != 0) begin
            errors++;
            $display("FAIL single_hold: extra writes=%0d idle cycles=%0d, required 0 and 0",
                     writes, idle_cycles);
        end
        bus.enable = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL single_release: BUSY=%b DONE=%b, required 0 1", bus.BUSY, bus.DONE);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trunc();
        test_saturation();
        test_offset();
        test_abort();
        test_rst_mid();
        test_continuous();
        test_single_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_avg_gain.md
ADC_AVG_GAIN -- requirements
Module: adc_avg_gain

Interface
REQ-001 Parameters SHALL be: ADC_WIDTH, default 12, sample width per channel (1..15); NUM_CH, default 2, channel count (>=1); LOG2_SAMPS, default 10, averaging depth exponent (NUM_SAMPS = 2^LOG2_SAMPS, 1..16); FLOAT_WIDTH, default 64, fixed-point word, format 16Q48 signed.
REQ-002 Ports SHALL be:
- ADC_CLK in 1 -- sole clock, rising edge.
- RST in 1 -- reset, synchronous, active-high.
- ADC_DATA_IN in NUM_CH*ADC_WIDTH -- unsigned samples; channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
- enable in 1 -- level request for conversion.
- CONTINUOUS in 1 -- 1 = free-running conversions while enable high.
- GAIN_IN in FLOAT_WIDTH -- signed 16Q48 gain, common to all channels.
- OFFSET_IN in FLOAT_WIDTH -- signed 16Q48 offset, common to all channels.
- DATA_OUT out NUM_CH*FLOAT_WIDTH -- scaled results; channel k at [k*FLOAT_WIDTH +: FLOAT_WIDTH].
- REG_WRITE out 1 -- one-cycle strobe, DATA_OUT newly valid.
- REG_RST out 1 -- one-cycle strobe at start of each conversion.
- BUSY out 1 -- high in any state other than IDLE.
- DONE out 1 -- high from first REG_WRITE until next REG_RST or reset.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, ACCUM, MUL, ADD, WRITE, HOLD.
REQ-004 IDLE -> CLEAR when enable sampled high; otherwise stay in IDLE.
REQ-005 CLEAR (1 cycle): zero all NUM_CH accumulators and the sample counter; latch GAIN_IN and OFFSET_IN; assert REG_RST; clear DONE.
REQ-006 ACCUM: exactly NUM_SAMPS cycles; each edge adds every channel's ADC_DATA_IN to its own (ADC_WIDTH+LOG2_SAMPS)-bit accumulator, with no overflow possible; counter wraps to 0 on the last sample, then -> MUL.
REQ-007 Average per channel SHALL be accumulator >> LOG2_SAMPS, truncated toward zero.
REQ-008 MUL (1 cycle, registered): signed product = zero-extended average x latched gain, giving Q48 with integer bits widened; saturate to FLOAT_WIDTH signed (max 64'h7FFF_FFFF_FFFF_FFFF, min 64'h8000_0000_0000_0000).
REQ-009 ADD (1 cycle, registered): saturated product + latched offset, saturated to the same limits.
REQ-010 WRITE (1 cycle): update all DATA_OUT channels simultaneously; assert REG_WRITE; set DONE.
REQ-011 From WRITE: if CONTINUOUS=1 and enable=1 -> CLEAR; else -> HOLD.
REQ-012 HOLD: stay while enable=1; -> IDLE when enable=0, so single-shot mode yields one conversion per enable assertion.
REQ-013 Latency: REG_WRITE SHALL assert exactly NUM_SAMPS+4 edges after the edge at which enable is first sampled high in IDLE; continuous period = NUM_SAMPS+4 cycles.
REQ-014 enable sampled low in CLEAR, ACCUM, MUL or ADD SHALL abort to IDLE next cycle, with no REG_WRITE and DATA_OUT/DONE unchanged.
REQ-015 GAIN_IN/OFFSET_IN changes after CLEAR SHALL NOT affect the conversion in progress.
REQ-016 DATA_OUT SHALL hold its value between REG_WRITE strobes.
REQ-017 REG_RST and REG_WRITE SHALL never be high in the same cycle.

Reset
REQ-018 RST high at an edge SHALL force IDLE and zero DATA_OUT, accumulators, counter, latched gain/offset, REG_WRITE, REG_RST, BUSY and DONE, taking priority over every other input, including mid-conversion.
REQ-019 After RST release, the first conversion SHALL follow REQ-004 with no spurious strobes.

Verification (bench: LOG2_SAMPS=2, NUM_CH=2)
REQ-020 Gain 64'h0001_0000_0000_0000, offset 0, ch0 constant 100, ch1 constant 0, enable pulse -> REG_WRITE 1 cycle at edge 8; DATA_OUT ch0 = 64'h0064_0000_0000_0000, ch1 = 0; DONE high.
REQ-021 Gain 1.0, ch0 samples 1,2,3,5 -> ch0 = 64'h0002_0000_0000_0000 (truncation).
REQ-022 Gain 64'h0014_0000_0000_0000, ch0 constant 12'hFFF -> ch0 = 64'h7FFF_FFFF_FFFF_FFFF (saturated); offset 64'hFFEC_0000_0000_0000 with gain 1.0, input 10 -> 64'hFFF6_0000_0000_0000.
REQ-023 enable dropped during ACCUM -> IDLE, no REG_WRITE, DATA_OUT keeps prior value; RST asserted mid-ACCUM -> all outputs zero next cycle.
REQ-024 CONTINUOUS=1, enable held high -> REG_WRITE every 8 cycles, each preceded by REG_RST; GAIN_IN changed mid-conversion -> new gain used only from the next conversion.
REQ-025 CONTINUOUS=0, enable held high -> exactly one REG_WRITE, FSM parked in HOLD with BUSY=1 until enable falls.
